tick_bcd_counter: RTL
=====================

TICK_BCD_COUNTER -- requirements
Module: tick_bcd_counter

Interface
REQ-001 SHALL have parameter MAX_TENS, default 5, meaning highest tens digit; modulus = (MAX_TENS+1)*10; legal range 0..9.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port div_in  input  1  divided square wave from the upstream clock-divider stage, synchronous to clk.
REQ-005 SHALL have port en  input  1  count enable.
REQ-006 SHALL have port clr  input  1  synchronous clear of digits.
REQ-007 SHALL have port dn  input  1  direction: 0 = up, 1 = down.
REQ-008 SHALL have port ones  output  4  BCD units digit, 0..9.
REQ-009 SHALL have port tens  output  4  BCD tens digit, 0..MAX_TENS.
REQ-010 SHALL have port tick  output  1  one-cycle pulse per detected div_in rising edge.
REQ-011 SHALL have port carry  output  1  one-cycle pulse on wrap (up) or borrow (down).

Function
REQ-012 SHALL hold registered copy div_prev of div_in, updated every clk edge regardless of en/clr.
REQ-013 SHALL define rise = div_in & ~div_prev, evaluated combinationally before each edge.
REQ-014 SHALL, at the edge where rise=1, set tick=1 for exactly that following cycle; otherwise tick=0; tick independent of en, clr, dn.
REQ-015 SHALL update digits at the same edge as tick (zero extra latency); a rise while en=0 SHALL leave digits unchanged.
REQ-016 Up step: ones<9 -> ones+1; ones=9 -> ones=0 and tens+1; at tens=MAX_TENS, ones=9 -> both 0 and carry=1.
REQ-017 Down step: ones>0 -> ones-1; ones=0 -> ones=9 and tens-1; at tens=0, ones=0 -> tens=MAX_TENS, ones=9, carry=1.
REQ-018 SHALL pulse carry for exactly one cycle, coincident with the tick of the wrapping step; carry=0 at all other times.
REQ-019 Priority SHALL be reset > clr > count step; clr=1 SHALL force ones=0, tens=0, carry=0 regardless of rise/en.
REQ-020 dn changing between ticks SHALL take effect at the next counted rise; no state other than digits depends on dn.
REQ-021 SHALL never present a digit outside 0..9 (ones) or 0..MAX_TENS (tens) after reset.
REQ-022 div_in held constant (0 or 1) SHALL produce no tick and no count change.

Reset
REQ-023 reset=1 at an edge SHALL set ones=0, tens=0, tick=0, carry=0, div_prev=1.
REQ-024 div_prev=1 after reset SHALL suppress a tick if div_in is already high on release; first tick requires div_in seen low then high.
REQ-025 Reset asserted mid-count or coincident with rise SHALL win; no tick/carry emitted on that edge.

Verification
REQ-026 Reset, en=1, dn=0, 25 div_in rising edges -> tens=2, ones=5, exactly 25 tick pulses, carry never high.
REQ-027 Preset via 59 rises, one more rise -> ones=0, tens=0, carry=1 for one cycle aligned with tick.
REQ-028 From 00 with dn=1, one rise -> tens=5, ones=9, carry=1 one cycle; next rise -> 58, carry=0.
REQ-029 div_in high during and after reset release -> no tick until div_in goes 0 then 1; then count 01.
REQ-030 At count 37, en=0 for 3 rises -> 3 ticks, count stays 37; clr=1 coincident with rise -> 00, tick=1, carry=0.
REQ-031 MAX_TENS=2, up from 29 -> 00 with carry=1; reset asserted on a rise edge at count 14 -> 00, tick=0.

Source files
------------

// File: rtl/tick_bcd_counter_if.sv
// tick_bcd_counter_if: groups the counter's control inputs (div_in, en, clr, dn) and digit/pulse outputs (ones, tens, tick, carry)
interface tick_bcd_counter_if;
  logic       div_in;
  logic       en;
  logic       clr;
  logic       dn;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       tick;
  logic       carry;
  modport master (output div_in, en, clr, dn, input ones, tens, tick, carry);
  modport slave (input div_in, en, clr, dn, output ones, tens, tick, carry);
endinterface

// File: rtl/tick_bcd_counter.sv
// tick_bcd_counter: up/down BCD counter stepping on div_in rising edges; ports clk, reset, bus (div_in/en/clr/dn in; ones/tens/tick/carry out)
module tick_bcd_counter #(
  parameter int MAX_TENS = 5
) (
  input logic               clk,
  input logic               reset,
  tick_bcd_counter_if.slave bus
);
  localparam logic [3:0] MT = 4'(MAX_TENS);
  logic       div_prev_q;
  logic [3:0] ones_q, ones_d, tens_q, tens_d;
  logic       tick_q, carry_q, carry_d;
  logic       rise, step;
  assign rise = bus.div_in & ~div_prev_q;
  assign step = rise & bus.en;
  always_comb begin
    ones_d  = ones_q;
    tens_d  = tens_q;
    carry_d = 1'b0;
    if (bus.clr) begin
      ones_d = 4'd0;
      tens_d = 4'd0;
    end else if (step && !bus.dn) begin
      carry_d = ones_q == 4'd9 && tens_q == MT;
      ones_d  = ones_q == 4'd9 ? 4'd0 : ones_q + 4'd1;
      tens_d  = ones_q != 4'd9 ? tens_q : carry_d ? 4'd0 : tens_q + 4'd1;
    end else if (step) begin
      carry_d = ones_q == 4'd0 && tens_q == 4'd0;
      ones_d  = ones_q == 4'd0 ? 4'd9 : ones_q - 4'd1;
      tens_d  = ones_q != 4'd0 ? tens_q : carry_d ? MT : tens_q - 4'd1;
    end
  end
  // div_prev resets high so a div_in already high at release is not taken as an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      div_prev_q <= 1'b1;
      ones_q     <= 4'd0;
      tens_q     <= 4'd0;
      tick_q     <= 1'b0;
      carry_q    <= 1'b0;
    end else begin
      div_prev_q <= bus.div_in;
      ones_q     <= ones_d;
      tens_q     <= tens_d;
      tick_q     <= rise;
      carry_q    <= carry_d;
    end
  end
  assign bus.ones  = ones_q;
  assign bus.tens  = tens_q;
  assign bus.tick  = tick_q;
  assign bus.carry = carry_q;
endmodule
